fetch_stage: RTL and testbench
==============================

# fetch_stage

IF pipeline stage of the SimpleMIPS core, between pre_IF and ID. It registers the fetch packet from pre_IF (`pfs_to_fs_bus_t`) and waits for the matching ICache `data_ok`. It buffers the returned word while ID stalls, then emits a `fs_to_ds_bus_t` packet. On pipeline flush it drops the current packet and discards every ICache response still in flight, so that stale instructions never reach ID.

## Interface
Parameters:
- `DISCARD_W`, default 2: width of the discard/pending counters. Up to 2^DISCARD_W−1 responses can be tracked.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pfs_to_fs_bus`  in  pfs_to_fs_bus_t  packet from pre_IF; `.valid` qualifies it.
- `fs_allowin`  out  1  IF can accept a packet this cycle.
- `ic_req_fire`  in  1  pulse when the ICache `req && addr_ok` handshake fires in pre_IF.
- `ic_data_ok`  in  1  ICache read-data strobe; responses return in request order.
- `ic_rdata`  in  32  ICache read data.
- `ds_allowin`  in  1  ID can accept a packet.
- `fs_to_ds_bus`  out  fs_to_ds_bus_t  packet to ID; `.valid` qualifies it.
- `flush`  in  1  OR of all `pipeline_flush_t` fields.
- `fs_discard_full`  out  1  discard counter is at its maximum; pre_IF must not fire a request.

## Operation
- State: `fs_valid`, `fs_pkt` (pc, req, exception), `buf_valid`, `buf_inst[31:0]`, `discard_cnt`.
- `ic_req_fire` is only asserted in a cycle where pre_IF also hands a packet with `req=1` into IF. This means at most one live, non-discarded request exists, and it belongs to IF's packet.
- Accept: when `pfs_to_fs_bus.valid && fs_allowin && !flush`, load `fs_pkt`, set `fs_valid`, clear `buf_valid`.
- Response routing:
  - If `ic_data_ok && discard_cnt!=0`, drop the response and decrement `discard_cnt`.
  - Otherwise, a response with `fs_valid && fs_pkt.req && !buf_valid` is the live response.
- `has_data = buf_valid | live ic_data_ok`. The instruction is `buf_valid ? buf_inst : ic_rdata`, a same-cycle bypass.
- `fs_ready_go = !fs_pkt.req | fs_pkt.exception.ex | has_data`. For an exception packet or `req=0`, the instruction is 32'h0.
- `fs_allowin = !fs_valid | (fs_ready_go & ds_allowin)`.
- `fs_to_ds_bus.valid = fs_valid & fs_ready_go & !flush`. The pc and exception fields pass through unchanged.
- A live response while `!ds_allowin` is captured into `buf_inst` and sets `buf_valid`. Handoff to ID clears the buffer.
- Flush:
  - Clear `fs_valid` and `buf_valid`.
  - Set `discard_cnt <= discard_cnt + (fs_valid & fs_pkt.req & !buf_valid) + ic_req_fire − ic_data_ok`. `ic_data_ok` in the flush cycle is always dropped.
  - The packet offered by pre_IF in the flush cycle is not accepted.
- `fs_discard_full = (discard_cnt == 2^DISCARD_W−1)`. Overflow of the counter is an assertion failure.

## Timing
- Reset values: `fs_valid=0`, `buf_valid=0`, `discard_cnt=0`, `fs_to_ds_bus='0`, `fs_discard_full=0`. `fs_allowin=1` during and after reset.
- Latency:
  - Zero cycles from `ic_data_ok` to `fs_to_ds_bus.valid`, since the path is combinational.
  - One cycle from pre_IF handoff to earliest ID handoff.
- Back-to-back throughput is one instruction per cycle when `data_ok` returns in the cycle after the fire.
- Data handling when `data_ok` and ID handoff coincide:
  - Data is bypassed and not buffered.
  - If ID stalls in that cycle, data is buffered and presented from `buf_inst` on later cycles.
- Flush asserted together with accept, data_ok and fire: flush wins. The packet is not accepted, the data is dropped, and the fire is counted as a discard.
- Reset asserted mid-request clears all state. Outstanding ICache responses are the ICache's responsibility; the ICache is reset together with IF.

## Configuration
- `FS_STALL_CNT_EN` defined: adds two 32-bit free-running counters, exported as output ports `fs_icwait_cnt` and `fs_dsstall_cnt`. Both reset to 0 and wrap at 2^32.
  - `fs_icwait_cnt` increments each cycle with `fs_valid & !fs_ready_go`.
  - `fs_dsstall_cnt` increments each cycle with `fs_valid & fs_ready_go & !ds_allowin`.
- `FS_STALL_CNT_EN` undefined: the counters and ports are absent; the behaviour above is otherwise identical.

## Test plan
- Basic fetch: pc=0xBFC00000 with `req=1` and fire in cycle 0, `data_ok` in cycle 2 with rdata=0x24080001 → `fs_to_ds_bus.valid=1` in cycle 2 with inst=0x24080001 and pc=0xBFC00000.
- ID stall: `data_ok` arrives while `ds_allowin=0` for 3 cycles → inst is held from the buffer and `valid` stays high. Exactly one handoff occurs when `ds_allowin` rises, and `buf_valid=0` after it.
- Exception packet: `exception.ex=1`, exccode=ADEL, badvaddr=0xBFC00001, `req=0` → valid in the next cycle with inst=0. No `data_ok` is waited on.
- Flush while waiting: `flush` while IF awaits data, with a fire in the same cycle → `discard_cnt=2`. The next two `data_ok` responses are dropped. The third response delivers the post-flush instruction with the correct pc.
- Saturation: three consecutive flushes with pending requests → `fs_discard_full=1`. No counter overflow occurs, and the counter decrements back to 0 as the responses drain.
- Async reset: assert `reset` mid-wait for half a cycle → `fs_to_ds_bus.valid=0` immediately, without waiting for a clock edge. Counters are 0 and `fs_allowin=1`.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage of the SimpleMIPS core: holds the pre_IF packet, matches it with the ICache response,
// buffers the word across ID stalls and discards stale responses after a flush. Option: FS_STALL_CNT_EN.
package fetch_stage_pkg;

  localparam logic [4:0] EXC_ADEL = 5'h04;

  typedef struct packed {
    logic        ex;
    logic [4:0]  exccode;
    logic [31:0] badvaddr;
  } exception_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        req;
    exception_t  exception;
  } pfs_to_fs_bus_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    exception_t  exception;
  } fs_to_ds_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        req;
    exception_t  exception;
  } fs_pkt_t;

endpackage

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned DISCARD_W = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  pfs_to_fs_bus_t pfs_to_fs_bus,
  output logic           fs_allowin,
  input  logic           ic_req_fire,
  input  logic           ic_data_ok,
  input  logic [31:0]    ic_rdata,
  input  logic           ds_allowin,
  output fs_to_ds_bus_t  fs_to_ds_bus,
  input  logic           flush,
`ifdef FS_STALL_CNT_EN
  output logic           fs_discard_full,
  output logic [31:0]    fs_icwait_cnt,
  output logic [31:0]    fs_dsstall_cnt
`else
  output logic           fs_discard_full
`endif
);

  localparam int unsigned CW = DISCARD_W + 1;
  localparam logic [DISCARD_W-1:0] DISCARD_MAX = '1;

  logic                 fs_valid;
  fs_pkt_t              fs_pkt;
  logic                 buf_valid;
  logic [31:0]          buf_inst;
  logic [DISCARD_W-1:0] discard_cnt;

  logic                 resp_drop;
  logic                 inflight;
  logic                 resp_live;
  logic                 has_data;
  logic                 fs_ready_go;
  logic                 fs_accept;
  logic                 out_valid;
  logic                 ds_handoff;
  logic [31:0]          inst;
  logic [CW-1:0]        discard_sum;

  always_comb begin
    resp_drop   = ic_data_ok & (discard_cnt != '0);
    // IF's own request is still outstanding: its response has not arrived yet
    inflight    = fs_valid & fs_pkt.req & ~buf_valid;
    resp_live   = ic_data_ok & ~resp_drop & inflight;
    has_data    = buf_valid | resp_live;
    fs_ready_go = ~fs_pkt.req | fs_pkt.exception.ex | has_data;
    fs_allowin  = ~fs_valid | (fs_ready_go & ds_allowin);
    fs_accept   = pfs_to_fs_bus.valid & fs_allowin & ~flush;
    out_valid   = fs_valid & fs_ready_go & ~flush;
    ds_handoff  = out_valid & ds_allowin;

    if (~fs_pkt.req | fs_pkt.exception.ex) begin
      inst = '0;
    end else if (buf_valid) begin
      inst = buf_inst;
    end else begin
      inst = ic_rdata;
    end

    // a flush-cycle data_ok always belongs to something being discarded
    discard_sum = CW'(discard_cnt) + CW'(inflight) + CW'(ic_req_fire) - CW'(ic_data_ok);

    fs_to_ds_bus = '0;
    if (out_valid) begin
      fs_to_ds_bus.valid     = 1'b1;
      fs_to_ds_bus.pc        = fs_pkt.pc;
      fs_to_ds_bus.inst      = inst;
      fs_to_ds_bus.exception = fs_pkt.exception;
    end

    fs_discard_full = (discard_cnt == DISCARD_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_valid    <= 1'b0;
      fs_pkt      <= '0;
      buf_valid   <= 1'b0;
      buf_inst    <= '0;
      discard_cnt <= '0;
    end else if (flush) begin
      fs_valid    <= 1'b0;
      buf_valid   <= 1'b0;
      discard_cnt <= discard_sum[DISCARD_W-1:0];
    end else begin
      if (resp_drop) begin
        discard_cnt <= discard_cnt - DISCARD_W'(1);
      end
      if (fs_accept) begin
        fs_valid         <= 1'b1;
        fs_pkt.pc        <= pfs_to_fs_bus.pc;
        fs_pkt.req       <= pfs_to_fs_bus.req;
        fs_pkt.exception <= pfs_to_fs_bus.exception;
        buf_valid        <= 1'b0;
      end else if (ds_handoff) begin
        fs_valid  <= 1'b0;
        buf_valid <= 1'b0;
      end else if (resp_live & ~ds_allowin) begin
        buf_valid <= 1'b1;
        buf_inst  <= ic_rdata;
      end
    end
  end

  a_discard_no_overflow: assert property (
    @(posedge clk) disable iff (reset) flush |-> (discard_sum[CW-1] == 1'b0)
  );

`ifdef FS_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_icwait_cnt  <= '0;
      fs_dsstall_cnt <= '0;
    end else begin
      if (fs_valid & ~fs_ready_go) begin
        fs_icwait_cnt <= fs_icwait_cnt + 32'd1;
      end
      if (fs_valid & fs_ready_go & ~ds_allowin) begin
        fs_dsstall_cnt <= fs_dsstall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected ID packets are queued when pre_IF hands them over
// and compared at every ID handoff; counters and flags are checked at chosen cycles.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic           clk;
  logic           reset;
  pfs_to_fs_bus_t pfs;
  logic           fs_allowin;
  logic           ic_req_fire;
  logic           ic_data_ok;
  logic [31:0]    ic_rdata;
  logic           ds_allowin;
  fs_to_ds_bus_t  fs_to_ds_bus;
  logic           flush;
  logic           fs_discard_full;
`ifdef FS_STALL_CNT_EN
  logic [31:0]    fs_icwait_cnt;
  logic [31:0]    fs_dsstall_cnt;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    exception_t  exc;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks;
  int unsigned errors;
  int unsigned handoffs;
  int unsigned h0;
  exception_t  no_exc;
  exception_t  adel;

  fetch_stage #(.DISCARD_W(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .pfs_to_fs_bus  (pfs),
    .fs_allowin     (fs_allowin),
    .ic_req_fire    (ic_req_fire),
    .ic_data_ok     (ic_data_ok),
    .ic_rdata       (ic_rdata),
    .ds_allowin     (ds_allowin),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .flush          (flush),
`ifdef FS_STALL_CNT_EN
    .fs_discard_full(fs_discard_full),
    .fs_icwait_cnt  (fs_icwait_cnt),
    .fs_dsstall_cnt (fs_dsstall_cnt)
`else
    .fs_discard_full(fs_discard_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    pfs         = '0;
    ic_req_fire = 1'b0;
    ic_data_ok  = 1'b0;
    ic_rdata    = '0;
    flush       = 1'b0;
    ds_allowin  = 1'b1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic req, input exception_t exc, input logic fire);
    pfs.valid     = 1'b1;
    pfs.pc        = pc;
    pfs.req       = req;
    pfs.exception = exc;
    ic_req_fire   = fire;
  endtask

  task automatic expect_pkt(input logic [31:0] pc, input logic [31:0] inst, input exception_t exc);
    exp_t e;
    e.pc   = pc;
    e.inst = inst;
    e.exc  = exc;
    sb.push_back(e);
  endtask

  // Sample at the falling edge; any ID handoff is matched against the scoreboard head.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (fs_to_ds_bus.valid && ds_allowin) begin
      handoffs++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_handoff observed pc=%0h expected no packet", fs_to_ds_bus.pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ho_pc",   128'(fs_to_ds_bus.pc),        128'(e.pc));
        chk("ho_inst", 128'(fs_to_ds_bus.inst),      128'(e.inst));
        chk("ho_exc",  128'(fs_to_ds_bus.exception), 128'(e.exc));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    handoffs = 0;
    no_exc   = '0;
    adel.ex       = 1'b1;
    adel.exccode  = EXC_ADEL;
    adel.badvaddr = 32'hBFC0_0001;
    reset = 1'b1;
    idle();

    // reset state
    sample();
    chk("rst_bus",     128'(fs_to_ds_bus),    128'(0));
    chk("rst_allowin", 128'(fs_allowin),      128'(1));
    chk("rst_full",    128'(fs_discard_full), 128'(0));
    chk("rst_discard", 128'(dut.discard_cnt), 128'(0));
    tick();
    reset = 1'b0;

    // basic fetch: fire in cycle 0, data_ok in cycle 2
    offer(32'hBFC0_0000, 1'b1, no_exc, 1'b1);
    expect_pkt(32'hBFC0_0000, 32'h2408_0001, no_exc);
    sample();
    chk("c0_allowin", 128'(fs_allowin), 128'(1));
    tick();
    idle();
    sample();
    chk("c1_valid", 128'(fs_to_ds_bus.valid), 128'(0));
    tick();
    ic_data_ok = 1'b1;
    ic_rdata   = 32'h2408_0001;
    sample();
    chk("c2_valid", 128'(fs_to_ds_bus.valid), 128'(1));
    tick();
    idle();

    // ID stall for 3 cycles with data buffered
    h0 = handoffs;
    offer(32'hBFC0_0004, 1'b1, no_exc, 1'b1);
    expect_pkt(32'hBFC0_0004, 32'h1111_1111, no_exc);
    sample();
    tick();
    idle();
    ds_allowin = 1'b0;
    ic_data_ok = 1'b1;
    ic_rdata   = 32'h1111_1111;
    sample();
    chk("stall_bypass_inst", 128'(fs_to_ds_bus.inst), 128'(32'h1111_1111));
    tick();
    for (int i = 0; i < 2; i++) begin
      ic_data_ok = 1'b0;
      ic_rdata   = 32'hDEAD_BEEF;
      sample();
      chk("stall_valid",   128'(fs_to_ds_bus.valid), 128'(1));
      chk("stall_inst",    128'(fs_to_ds_bus.inst),  128'(32'h1111_1111));
      chk("stall_buf_vld", 128'(dut.buf_valid),      128'(1));
      tick();
    end
    ds_allowin = 1'b1;
    sample();
    tick();
    idle();
    sample();
    chk("stall_handoffs", 128'(handoffs - h0),        128'(1));
    chk("stall_buf_clr",  128'(dut.buf_valid),        128'(0));
    chk("stall_after_v",  128'(fs_to_ds_bus.valid),   128'(0));

    // exception packet, no request
    offer(32'hBFC0_0001, 1'b0, adel, 1'b0);
    expect_pkt(32'hBFC0_0001, 32'h0, adel);
    tick();
    idle();
    sample();
    chk("exc_valid", 128'(fs_to_ds_bus.valid), 128'(1));
    tick();

    // back-to-back: one instruction per cycle
    h0 = handoffs;
    offer(32'h0000_1000, 1'b1, no_exc, 1'b1);
    expect_pkt(32'h0000_1000, 32'hA000_0000, no_exc);
    sample();
    tick();
    for (int i = 1; i <= 3; i++) begin
      idle();
      ic_data_ok = 1'b1;
      ic_rdata   = 32'hA000_0000 + 32'(i - 1);
      if (i < 3) begin
        offer(32'h0000_1000 + 32'(4 * i), 1'b1, no_exc, 1'b1);
        expect_pkt(32'h0000_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), no_exc);
      end
      sample();
      chk("b2b_allowin", 128'(fs_allowin), 128'(1));
      tick();
    end
    idle();
    chk("b2b_handoffs", 128'(handoffs - h0), 128'(3));

    // flush while waiting, with a fire in the flush cycle
    offer(32'hBFC0_0008, 1'b1, no_exc, 1'b1);
    sample();
    tick();
    idle();
    flush = 1'b1;
    offer(32'hBFC0_000C, 1'b1, no_exc, 1'b1);
    sample();
    chk("flush_valid", 128'(fs_to_ds_bus.valid), 128'(0));
    tick();
    idle();
    ic_data_ok = 1'b1;
    ic_rdata   = 32'hBAD0_0001;
    sample();
    chk("flush_discard2", 128'(dut.discard_cnt),    128'(2));
    chk("flush_drop1_v",  128'(fs_to_ds_bus.valid), 128'(0));
    tick();
    offer(32'hBFC0_0010, 1'b1, no_exc, 1'b1);
    expect_pkt(32'hBFC0_0010, 32'h3C1D_A000, no_exc);
    ic_rdata = 32'hBAD0_0002;
    sample();
    chk("flush_discard1", 128'(dut.discard_cnt), 128'(1));
    tick();
    idle();
    ic_data_ok = 1'b1;
    ic_rdata   = 32'h3C1D_A000;
    sample();
    chk("flush_third_v", 128'(fs_to_ds_bus.valid), 128'(1));
    tick();
    idle();
    sample();
    chk("flush_discard0", 128'(dut.discard_cnt), 128'(0));
    tick();

    // saturation: three flushes with a pending request each
    for (int i = 1; i <= 3; i++) begin
      offer(32'h0000_2000 + 32'(4 * i), 1'b1, no_exc, 1'b1);
      sample();
      chk("sat_full_pre", 128'(fs_discard_full), 128'(0));
      tick();
      idle();
      flush = 1'b1;
      sample();
      tick();
      idle();
    end
    for (int i = 3; i >= 1; i--) begin
      ic_data_ok = 1'b1;
      ic_rdata   = 32'hBAD0_0010;
      sample();
      chk("sat_drain_cnt", 128'(dut.discard_cnt),    128'(i));
      chk("sat_drain_v",   128'(fs_to_ds_bus.valid), 128'(0));
      if (i == 3) chk("sat_full", 128'(fs_discard_full), 128'(1));
      tick();
    end
    idle();
    sample();
    chk("sat_cnt0",  128'(dut.discard_cnt), 128'(0));
    chk("sat_full0", 128'(fs_discard_full), 128'(0));
    tick();

    // flush together with accept, data_ok and fire
    offer(32'h0000_3000, 1'b1, no_exc, 1'b1);
    sample();
    tick();
    idle();
    flush = 1'b1;
    offer(32'h0000_3004, 1'b1, no_exc, 1'b1);
    ic_data_ok = 1'b1;
    ic_rdata   = 32'hBAD0_0020;
    sample();
    chk("fall_valid", 128'(fs_to_ds_bus.valid), 128'(0));
    tick();
    idle();
    ic_data_ok = 1'b1;
    ic_rdata   = 32'hBAD0_0021;
    sample();
    chk("fall_discard", 128'(dut.discard_cnt), 128'(1));
    chk("fall_no_acc",  128'(dut.fs_valid),    128'(0));
    tick();
    idle();
    sample();
    chk("fall_drained", 128'(dut.discard_cnt), 128'(0));
    tick();

    // asynchronous reset in the middle of a wait
    offer(32'h0000_4000, 1'b1, no_exc, 1'b1);
    tick();
    idle();
    ic_data_ok = 1'b1;
    ic_rdata   = 32'h1234_5678;
    #1;
    chk("arst_pre_valid", 128'(fs_to_ds_bus.valid), 128'(1));
    reset = 1'b1;
    #1;
    chk("arst_valid",   128'(fs_to_ds_bus.valid), 128'(0));
    chk("arst_allowin", 128'(fs_allowin),         128'(1));
    chk("arst_discard", 128'(dut.discard_cnt),    128'(0));
    chk("arst_full",    128'(fs_discard_full),    128'(0));
    idle();
    #4;
    reset = 1'b0;
    sample();
    chk("arst_after_v",   128'(fs_to_ds_bus.valid), 128'(0));
    chk("arst_after_fsv", 128'(dut.fs_valid),       128'(0));
    chk("arst_after_alw", 128'(fs_allowin),         128'(1));
    tick();

    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
